// File: rtl/nv_nvdla_cacc_abuf_rmw_ctrl.sv
// Read-modify-write accumulator in front of the CACC assembly buffer.
// Four-stage pipe (issue read, wait, add, write back) with a 3-entry write forwarding window.

module nv_nvdla_cacc_abuf_rmw_lane #(
    parameter int IN_W  = 22,
    parameter int ACC_W = 34
) (
    input  logic [IN_W-1:0]  in_i,
    input  logic [ACC_W-1:0] old_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sat_o
);
    logic [ACC_W:0] wide;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign wide  = {old_i[ACC_W-1], old_i} + {{(ACC_W+1-IN_W){in_i[IN_W-1]}}, in_i};
    assign sat_o = wide[ACC_W] ^ wide[ACC_W-1];

    always_comb begin
        sum_o = wide[ACC_W-1:0];
        if (sat_o) begin
            sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

module nv_nvdla_cacc_abuf_rmw_ctrl #(
    parameter int LANES = 8,
    parameter int IN_W  = 22,
    parameter int ACC_W = 34,
    parameter int AW    = 6
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   in_valid,
    input  logic [AW-1:0]          in_addr,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   sat_clr,
    output logic                   abuf_rd_en,
    output logic [AW-1:0]          abuf_rd_addr,
    input  logic [LANES*ACC_W-1:0] abuf_rd_data,
    output logic                   abuf_wr_en,
    output logic [AW-1:0]          abuf_wr_addr,
    output logic [LANES*ACC_W-1:0] abuf_wr_data,
    output logic                   out_valid,
    output logic [AW-1:0]          out_addr,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic [31:0]            sat_cnt
);
    localparam int CW = $clog2(LANES + 1);

    typedef struct packed {
        logic [AW-1:0]                 addr;
        logic [LANES-1:0][IN_W-1:0]    data;
        logic                          first;
        logic                          last;
    } req_t;

    req_t                        in_req, s1_q, s2_q, s3_q;
    logic [6:1]                  vld_pipe_q;  // [1..3] S1..S3, [4] S4/W0, [5] W1, [6] W2
    logic [AW-1:0]               w0_addr_q, w1_addr_q, w2_addr_q;
    logic [LANES-1:0][ACC_W-1:0] w0_data_q, w1_data_q, w2_data_q;
    logic                        w0_last_q;
    logic [CW-1:0]               w0_nsat_q;
    logic [LANES-1:0][ACC_W-1:0] rd_data, old_d, sum_d;
    logic [LANES-1:0]            sat_d;
    logic [CW-1:0]               nsat_d;
    logic [32:0]                 sat_sum;
    logic [31:0]                 sat_cnt_q, sat_cnt_d;

    assign in_req  = '{addr: in_addr, data: in_data, first: in_first, last: in_last};
    assign rd_data = abuf_rd_data;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_pipe_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[5:1], in_valid};
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        s1_q      <= in_req;
        s2_q      <= s1_q;
        s3_q      <= s2_q;
        w0_addr_q <= s3_q.addr;
        w0_data_q <= sum_d;
        w0_last_q <= s3_q.last;
        w0_nsat_q <= nsat_d;
        w1_addr_q <= w0_addr_q;
        w1_data_q <= w0_data_q;
        w2_addr_q <= w1_addr_q;
        w2_data_q <= w1_data_q;
    end

    // Writes from the last 3 cycles are not yet visible to the read issued 2 cycles ago.
    always_comb begin
        old_d = rd_data;
        if (s3_q.first)
            old_d = '0;
        else if (vld_pipe_q[4] && w0_addr_q == s3_q.addr)
            old_d = w0_data_q;
        else if (vld_pipe_q[5] && w1_addr_q == s3_q.addr)
            old_d = w1_data_q;
        else if (vld_pipe_q[6] && w2_addr_q == s3_q.addr)
            old_d = w2_data_q;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nv_nvdla_cacc_abuf_rmw_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
            .in_i  (s3_q.data[g]),
            .old_i (old_d[g]),
            .sum_o (sum_d[g]),
            .sat_o (sat_d[g])
        );
    end

    always_comb begin
        nsat_d = '0;
        for (int i = 0; i < LANES; i++) nsat_d = nsat_d + CW'(sat_d[i]);
    end

    assign sat_sum = {1'b0, sat_cnt_q} + 33'(w0_nsat_q);

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (vld_pipe_q[4])
            sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end

    assign abuf_rd_en   = vld_pipe_q[1] & ~s1_q.first;
    assign abuf_rd_addr = s1_q.addr;
    assign abuf_wr_en   = vld_pipe_q[4];
    assign abuf_wr_addr = w0_addr_q;
    assign abuf_wr_data = w0_data_q;
    assign out_valid    = vld_pipe_q[4] & w0_last_q;
    assign out_addr     = w0_addr_q;
    assign out_data     = w0_data_q;
    assign sat_cnt      = sat_cnt_q;
endmodule

// File: tb/tb_nv_nvdla_cacc_abuf_rmw_ctrl.sv
// Scoreboard bench for the CACC RMW accumulator: directed stripes with hand-computed
// per-lane results, a 2-cycle-latency buffer model, and a write-port monitor.
module tb_nv_nvdla_cacc_abuf_rmw_ctrl;
    localparam int LANES = 8;
    localparam int IN_W  = 22;
    localparam int ACC_W = 34;
    localparam int AW    = 6;
    localparam int DW    = LANES * ACC_W;
    localparam logic [ACC_W-1:0] MAXV = 34'h1_FFFF_FFFF;
    localparam logic [ACC_W-1:0] MINV = 34'h2_0000_0000;

    logic                  clk, rstn;
    logic                  in_valid, in_first, in_last, sat_clr;
    logic [AW-1:0]         in_addr;
    logic [LANES*IN_W-1:0] in_data;
    logic                  abuf_rd_en, abuf_wr_en, out_valid;
    logic [AW-1:0]         abuf_rd_addr, abuf_wr_addr, out_addr;
    logic [DW-1:0]         abuf_rd_data, abuf_wr_data, out_data;
    logic [31:0]           sat_cnt;

    nv_nvdla_cacc_abuf_rmw_ctrl #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .AW(AW)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .sat_clr(sat_clr),
        .abuf_rd_en(abuf_rd_en), .abuf_rd_addr(abuf_rd_addr), .abuf_rd_data(abuf_rd_data),
        .abuf_wr_en(abuf_wr_en), .abuf_wr_addr(abuf_wr_addr), .abuf_wr_data(abuf_wr_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: read data appears 2 cycles after the strobe; read-during-write gives old data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_a;
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (abuf_rd_en) rd_a <= mem[abuf_rd_addr];
        abuf_rd_data <= rd_a;
        if (abuf_wr_en) mem[abuf_wr_addr] <= abuf_wr_data;
        if (pre_en) mem[pre_addr] <= pre_data;
    end

    typedef struct {
        logic [AW-1:0]    addr;
        logic [ACC_W-1:0] val;
        logic             last;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int rd_cnt = 0;

    function automatic logic [DW-1:0] rep(input logic [ACC_W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected result.
    always @(negedge clk) begin
        if (rstn) begin
            if (abuf_rd_en) rd_cnt++;
            if (abuf_wr_en) begin
                chk("sb_nonempty", DW'(sb.size() != 0), DW'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", DW'(abuf_wr_addr), DW'(e.addr));
                    chk("wr_data", abuf_wr_data, rep(e.val));
                    chk("out_valid", DW'(out_valid), DW'(e.last));
                    if (e.last) begin
                        chk("out_addr", DW'(out_addr), DW'(e.addr));
                        chk("out_data", out_data, rep(e.val));
                    end
                end
            end else if (out_valid) begin
                chk("out_without_wr", DW'(out_valid), DW'(0));
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input int v, input bit f, input bit l,
                        input logic [ACC_W-1:0] e, input bit push);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        for (int i = 0; i < LANES; i++) in_data[i*IN_W +: IN_W] = IN_W'(v);
        in_first = f;
        in_last  = l;
        if (push) sb.push_back('{a, e, l});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [ACC_W-1:0] v);
        @(negedge clk);
        in_valid = 1'b0;
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = rep(v);
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Addr-3 stripe 10,20,30,40 with a fixed gap between inputs.
    task automatic stripe3(input int gap);
        send(3, 10, 1, 0, 10, 1);  idle(gap);
        send(3, 20, 0, 0, 30, 1);  idle(gap);
        send(3, 30, 0, 0, 60, 1);  idle(gap);
        send(3, 40, 0, 1, 100, 1); idle(8);
    endtask

    initial begin
        int r0;
        rstn = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sat_clr = 1'b0;
        in_addr = '0; in_data = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", DW'({abuf_rd_en, abuf_wr_en, out_valid}), DW'(0));
        chk("reset_sat_cnt", DW'(sat_cnt), DW'(0));
        rstn = 1'b1;
        idle(2);

        // 1: first+last, no read issued
        r0 = rd_cnt;
        send(5, 100, 1, 1, 100, 1); idle(8);
        chk("t1_no_read", DW'(rd_cnt - r0), DW'(0));

        // 2: back-to-back same address, W0 forwarding
        r0 = rd_cnt;
        stripe3(0);
        chk("t2_reads", DW'(rd_cnt - r0), DW'(3));

        // 3: W1, W2 and buffer paths
        stripe3(1);
        stripe3(2);
        stripe3(3);

        // 4: interleaved addresses must not cross-forward
        send(1, 7, 1, 0, 7, 1);
        send(2, 7, 1, 0, 7, 1);
        send(1, 7, 0, 1, 14, 1);
        send(2, 7, 0, 1, 14, 1);
        idle(8);

        // negative partials
        send(4, -50, 1, 0, -50, 1);
        send(4, 20, 0, 1, -30, 1);
        idle(8);

        // 5: overflow clamp, sat_cnt, clear priority
        preload(9, MAXV - 34'd1);
        idle(4);
        send(9, 5, 0, 1, MAXV, 1); idle(8);
        chk("t5_sat_cnt", DW'(sat_cnt), DW'(8));
        send(9, 5, 0, 1, MAXV, 1); idle(3);
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0;
        chk("t5_sat_clr_prio", DW'(sat_cnt), DW'(0));
        idle(4);

        // underflow clamp
        preload(10, MINV + 34'd1);
        idle(4);
        send(10, -5, 0, 1, MINV, 1); idle(8);
        chk("underflow_sat_cnt", DW'(sat_cnt), DW'(8));

        // 6: reset with 3 inputs in flight
        send(7, 1, 1, 0, 0, 0);
        send(7, 1, 0, 0, 0, 0);
        send(7, 1, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("t6_rst_strobes", DW'({abuf_rd_en, abuf_wr_en, out_valid}), DW'(0));
        chk("t6_rst_sat_cnt", DW'(sat_cnt), DW'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(8);
        send(7, 3, 1, 0, 3, 1);
        send(7, 4, 0, 1, 7, 1);
        idle(8);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", DW'(sb.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
